// File: rtl/fx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fx_pkg
//  Description : Shared Q-format helpers, default widths and saturation limits
//                for the fixed-point MAC pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
package fx_pkg;

    localparam int FX_DEF_INT_BITS   = 8;
    localparam int FX_DEF_FRAC_BITS  = 24;
    localparam int FX_DEF_GUARD_BITS = 8;
    localparam int FX_DEF_SATURATE   = 1;

    // Wide enough for any limit constant this block is ever configured with.
    localparam int FX_LIM_W = 128;

    function automatic int fx_width(input int int_bits, input int frac_bits);
        return int_bits + frac_bits;
    endfunction

    function automatic int fx_acc_width(input int width, input int guard_bits);
        return width + guard_bits;
    endfunction

    function automatic logic [FX_LIM_W-1:0] fx_max_pos(input int width);
        return (FX_LIM_W'(1) << (width - 1)) - FX_LIM_W'(1);
    endfunction

    function automatic logic [FX_LIM_W-1:0] fx_min_neg(input int width);
        return ~fx_max_pos(width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fx_mul_shift.sv
`default_nettype none
// ============================================================================
//  Module      : fx_mul_shift
//  Description : Signed W x W multiply, floor shift by FRAC_BITS, sign-extended
//                to the accumulator width and registered (pipeline stage S2).
//  Revision    : 1.0 - initial release
// ============================================================================
module fx_mul_shift
    import fx_pkg::*;
#(
    parameter int  INT_BITS   = FX_DEF_INT_BITS,
    parameter int  FRAC_BITS  = FX_DEF_FRAC_BITS,
    parameter int  GUARD_BITS = FX_DEF_GUARD_BITS,
    localparam int W          = fx_width(INT_BITS, FRAC_BITS),
    localparam int AW         = fx_acc_width(W, GUARD_BITS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_en,
    input  logic          i_flush,
    input  logic          i_valid,
    input  logic          i_last,
    input  logic [W-1:0]  i_a,
    input  logic [W-1:0]  i_b,
    output logic          o_valid,
    output logic          o_last,
    output logic [AW-1:0] o_prod
);

    logic signed [2*W-1:0] w_full;
    logic                  r_valid;
    logic                  r_last;
    logic [AW-1:0]         r_prod;

    assign w_full = $signed(i_a) * $signed(i_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_prod  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_en) begin
            r_valid <= i_valid;
            r_last  <= i_last;
            // Arithmetic shift gives floor rounding; the cast sign-extends.
            r_prod  <= AW'(w_full >>> FRAC_BITS);
        end
    end

    assign o_valid = r_valid;
    assign o_last  = r_last;
    assign o_prod  = r_prod;

endmodule
`default_nettype wire

// File: rtl/fx_mac_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fx_mac_pipe
//  Description : Three-stage fixed-point dot-product MAC with guard-bit
//                accumulator, saturate/wrap output and ready/valid flow control.
//  Revision    : 1.0 - initial release
// ============================================================================
module fx_mac_pipe
    import fx_pkg::*;
#(
    parameter int  INT_BITS   = FX_DEF_INT_BITS,
    parameter int  FRAC_BITS  = FX_DEF_FRAC_BITS,
    parameter int  GUARD_BITS = FX_DEF_GUARD_BITS,
    parameter int  SATURATE   = FX_DEF_SATURATE,
    localparam int W          = fx_width(INT_BITS, FRAC_BITS),
    localparam int AW         = fx_acc_width(W, GUARD_BITS)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         in_last,
    input  logic         clr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         overflow
);

    localparam logic signed [AW-1:0] c_acc_max = AW'(fx_max_pos(AW));
    localparam logic signed [AW-1:0] c_acc_min = AW'(fx_min_neg(AW));
    localparam logic signed [AW-1:0] c_res_max = AW'(fx_max_pos(W));
    localparam logic signed [AW-1:0] c_res_min = AW'(fx_min_neg(W));

    logic                 w_stall;
    logic                 w_accept;
    logic                 r_s1_valid;
    logic                 r_s1_last;
    logic [W-1:0]         r_s1_a;
    logic [W-1:0]         r_s1_b;
    logic                 w_s2_valid;
    logic                 w_s2_last;
    logic [AW-1:0]        w_s2_prod;
    logic signed [AW-1:0] r_acc;
    logic                 r_sticky;
    logic                 r_out_valid;
    logic [W-1:0]         r_result;
    logic                 r_overflow;
    logic signed [AW:0]   w_sum_ext;
    logic                 w_acc_ovf;
    logic signed [AW-1:0] w_acc_next;
    logic                 w_acc_sticky;
    logic                 w_res_hi;
    logic                 w_res_lo;
    logic [W-1:0]         w_res;
    logic                 w_accum;
    logic                 w_emit;

    assign w_stall  = r_out_valid && !out_ready;
    assign in_ready = !w_stall;
    assign w_accept = in_valid && in_ready;

    // S1: operand register. A beat taken in a clr cycle starts the new vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else begin
            if (clr) begin
                r_s1_valid <= w_accept;
            end else if (!w_stall) begin
                r_s1_valid <= in_valid;
            end
            if (w_accept) begin
                r_s1_last <= in_last;
                r_s1_a    <= a;
                r_s1_b    <= b;
            end
        end
    end

    fx_mul_shift #(
        .INT_BITS   (INT_BITS),
        .FRAC_BITS  (FRAC_BITS),
        .GUARD_BITS (GUARD_BITS)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (!w_stall),
        .i_flush (clr),
        .i_valid (r_s1_valid),
        .i_last  (r_s1_last),
        .i_a     (r_s1_a),
        .i_b     (r_s1_b),
        .o_valid (w_s2_valid),
        .o_last  (w_s2_last),
        .o_prod  (w_s2_prod)
    );

    // S3 datapath: saturating AW-bit add, then W-range check of the new sum.
    assign w_sum_ext    = {r_acc[AW-1], r_acc} + {w_s2_prod[AW-1], w_s2_prod};
    assign w_acc_ovf    = w_sum_ext[AW] ^ w_sum_ext[AW-1];
    assign w_acc_next   = w_acc_ovf ? (w_sum_ext[AW] ? c_acc_min : c_acc_max)
                                    : w_sum_ext[AW-1:0];
    assign w_acc_sticky = r_sticky | w_acc_ovf;
    assign w_res_hi     = w_acc_next > c_res_max;
    assign w_res_lo     = w_acc_next < c_res_min;

    generate
        if (SATURATE != 0) begin : g_sat
            assign w_res = w_res_hi ? c_res_max[W-1:0] :
                           w_res_lo ? c_res_min[W-1:0] : w_acc_next[W-1:0];
        end else begin : g_wrap
            assign w_res = w_acc_next[W-1:0];
        end
    endgenerate

    assign w_accum = !clr && !w_stall && w_s2_valid;
    assign w_emit  = w_accum && w_s2_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_sticky    <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_overflow  <= 1'b0;
        end else begin
            // Clearing on the emit edge lets the next vector follow with no gap.
            if (clr || w_emit) begin
                r_acc    <= '0;
                r_sticky <= 1'b0;
            end else if (w_accum) begin
                r_acc    <= w_acc_next;
                r_sticky <= w_acc_sticky;
            end
            if (w_emit) begin
                r_result    <= w_res;
                r_overflow  <= w_res_hi | w_res_lo | w_acc_sticky;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_fx_mac_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fx_mac_pipe
//  Description : Directed self-checking bench for fx_mac_pipe (saturating and
//                wrapping instances driven with identical stimulus).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fx_mac_pipe;

    localparam int W = 32;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_last   = 1'b0;
    logic         clr       = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;

    logic         in_ready,   out_valid,   overflow;
    logic [W-1:0] result;
    logic         in_ready_w, out_valid_w, overflow_w;
    logic [W-1:0] result_w;

    int           n_checks = 0;
    int           n_pass   = 0;
    logic [65:0]  q[$];

    fx_mac_pipe #(.SATURATE(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .in_last(in_last), .clr(clr), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .overflow(overflow)
    );

    fx_mac_pipe #(.SATURATE(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
        .a(a), .b(b), .in_last(in_last), .clr(clr), .out_valid(out_valid_w),
        .out_ready(out_ready), .result(result_w), .overflow(overflow_w)
    );

    always #5 clk = ~clk;

    // Capture every handshaken result (wrap-instance fields in the upper half).
    always @(posedge clk)
        if (rst_n && out_valid && out_ready)
            q.push_back({overflow_w, result_w, overflow, result});

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_checks++;
        if (obs === want) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, want);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vl);
        int n;
        n        = 0;
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        in_last  = vl;
        while (!in_ready && n < 50) begin
            tick(1);
            n++;
        end
        if (n >= 50) chk("send_timeout", 64'd1, 64'd0);
        tick(1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic get_result(input string tag, input logic [W-1:0] want_res, input logic want_ovf,
                              input bit check_w, input logic [W-1:0] want_res_w,
                              input logic want_ovf_w);
        int          n;
        logic [65:0] e;
        n = 0;
        while (q.size() == 0 && n < 30) begin
            tick(1);
            n++;
        end
        if (q.size() == 0) begin
            chk({tag, "_timeout"}, 64'd1, 64'd0);
        end else begin
            e = q.pop_front();
            chk({tag, "_result"}, 64'(e[31:0]), 64'(want_res));
            chk({tag, "_ovf"}, 64'(e[32]), 64'(want_ovf));
            if (check_w) begin
                chk({tag, "_wrap_result"}, 64'(e[64:33]), 64'(want_res_w));
                chk({tag, "_wrap_ovf"}, 64'(e[65]), 64'(want_ovf_w));
            end
        end
    endtask

    initial begin
        // Reset state
        tick(2);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        rst_n = 1'b1;
        tick(1);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Single beat 1.5 x 2.0, latency 3
        send(32'h0180_0000, 32'h0200_0000, 1'b1);
        chk("lat_c1", 64'(out_valid), 64'd0);
        tick(1);
        chk("lat_c2", 64'(out_valid), 64'd0);
        tick(1);
        chk("lat_c3_valid", 64'(out_valid), 64'd1);
        chk("lat_c3_result", 64'(result), 64'h0300_0000);
        chk("lat_c3_ovf", 64'(overflow), 64'd0);
        get_result("single", 32'h0300_0000, 1'b0, 1'b0, '0, 1'b0);

        // (-1.0 x 0.5) + (0.25 x 1.0) = -0.25
        send(32'hFF00_0000, 32'h0080_0000, 1'b0);
        send(32'h0040_0000, 32'h0100_0000, 1'b1);
        get_result("dot2", 32'hFFC0_0000, 1'b0, 1'b0, '0, 1'b0);

        // Floor rounding: 2^-24 x -0.5 -> -1 LSB
        send(32'h0000_0001, 32'hFF80_0000, 1'b1);
        get_result("floor", 32'hFFFF_FFFF, 1'b0, 1'b0, '0, 1'b0);

        // Positive and negative out-of-range: clamp vs wrap
        send(32'h6400_0000, 32'h0200_0000, 1'b1);
        get_result("ovf_pos", 32'h7FFF_FFFF, 1'b1, 1'b1, 32'hC800_0000, 1'b1);
        send(32'h9C00_0000, 32'h0200_0000, 1'b1);
        get_result("ovf_neg", 32'h8000_0000, 1'b1, 1'b1, 32'h3800_0000, 1'b1);

        // Back-to-back one-term vectors
        send(32'h0100_0000, 32'h0100_0000, 1'b1);
        send(32'h0200_0000, 32'h0100_0000, 1'b1);
        get_result("b2b_0", 32'h0100_0000, 1'b0, 1'b0, '0, 1'b0);
        get_result("b2b_1", 32'h0200_0000, 1'b0, 1'b0, '0, 1'b0);

        // Stall with two vectors in flight
        out_ready = 1'b0;
        send(32'h0100_0000, 32'h0100_0000, 1'b0);
        send(32'h0100_0000, 32'h0100_0000, 1'b1);
        send(32'h0080_0000, 32'h0080_0000, 1'b1);
        tick(1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_result", 64'(result), 64'h0200_0000);
            tick(1);
        end
        chk("stall_none_taken", 64'(q.size()), 64'd0);
        out_ready = 1'b1;
        get_result("stall_a", 32'h0200_0000, 1'b0, 1'b0, '0, 1'b0);
        get_result("stall_b", 32'h0040_0000, 1'b0, 1'b0, '0, 1'b0);

        // clr with partial sum spread over S1/S2/acc, then 1.0 x 1.0
        send(32'h0200_0000, 32'h0100_0000, 1'b0);
        send(32'h0200_0000, 32'h0100_0000, 1'b0);
        send(32'h0200_0000, 32'h0100_0000, 1'b0);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        send(32'h0100_0000, 32'h0100_0000, 1'b1);
        get_result("clr", 32'h0100_0000, 1'b0, 1'b0, '0, 1'b0);
        tick(10);
        chk("clr_no_extra", 64'(q.size()), 64'd0);

        // Beat accepted in the clr cycle starts the new vector: 1.0 + 0.5
        send(32'h0200_0000, 32'h0100_0000, 1'b0);
        clr = 1'b1;
        send(32'h0080_0000, 32'h0200_0000, 1'b0);
        clr = 1'b0;
        send(32'h0080_0000, 32'h0100_0000, 1'b1);
        get_result("clr_beat", 32'h0180_0000, 1'b0, 1'b0, '0, 1'b0);

        // Asynchronous reset mid-vector with a result pending
        out_ready = 1'b0;
        send(32'h0100_0000, 32'h0100_0000, 1'b1);
        send(32'h0300_0000, 32'h0100_0000, 1'b0);
        tick(1);
        chk("prerst_out_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_result", 64'(result), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        tick(2);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick(1);
        chk("arst_no_result", 64'(q.size()), 64'd0);
        send(32'h0080_0000, 32'h0080_0000, 1'b1);
        get_result("post_rst", 32'h0040_0000, 1'b0, 1'b0, '0, 1'b0);
        tick(5);
        chk("post_rst_no_extra", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
